// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder feeding a 2-entry output FIFO with a sideband tag.
// Define IMM_GEN_ZICSR_EN to decode CSR immediate forms (zimm) as type Z.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_Z    = 3'd6;

  logic [2:0]      dec_type;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_type = T_NONE;
    imm32    = '0;
    case (in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: dec_type = T_I;
      7'b0011011: dec_type = (XLEN == 64) ? T_I : T_NONE;
      7'b0100011: dec_type = T_S;
      7'b1100011: dec_type = T_B;
      7'b0110111, 7'b0010111: dec_type = T_U;
      7'b1101111: dec_type = T_J;
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: dec_type = in_inst[14] ? T_Z : T_NONE;
`endif
      default: dec_type = T_NONE;
    endcase

    case (dec_type)
      T_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      T_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      T_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
      T_U: imm32 = {in_inst[31:12], 12'b0};
      T_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    // Every 32-bit form carries its sign in bit 31, so widening is a plain sign extension.
    dec_imm = XLEN'(signed'(imm32));
`ifdef IMM_GEN_ZICSR_EN
    if (dec_type == T_Z) dec_imm = XLEN'(in_inst[19:15]);
`endif
  end

  logic [XLEN-1:0]  imm_mem  [2];
  logic [2:0]       type_mem [2];
  logic [TAG_W-1:0] tag_mem  [2];

  logic [1:0] count_reg;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic       push;
  logic       pop;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr_reg]  <= dec_imm;
      type_mem[wr_ptr_reg] <= dec_type;
      tag_mem[wr_ptr_reg]  <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else if (flush) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      if (push && !pop)      count_reg <= count_reg + 2'd1;
      else if (pop && !push) count_reg <= count_reg - 2'd1;
    end
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign out_imm  = out_valid ? imm_mem[rd_ptr_reg]  : '0;
  assign out_type = out_valid ? type_mem[rd_ptr_reg] : 3'd0;
  assign out_tag  = out_valid ? tag_mem[rd_ptr_reg]  : '0;

endmodule
